// File: rtl/nonce_sweep_pkg.sv
// ---------------------------------------------------------------------------
// nonce_sweep_pkg
// Shared definitions for the nonce sweep controller: the controller state
// encoding and the default geometry of the hash pipeline it drives.
// ---------------------------------------------------------------------------
package nonce_sweep_pkg;

    localparam int NS_WORDBITS  = 32;
    localparam int NS_MSGWORDS  = 16;
    localparam int NS_HASHWORDS = 8;
    localparam int NS_PIPE_LAT  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2
    } sweep_state_t;

endpackage

// File: rtl/nonce_hit_fifo.sv
// ---------------------------------------------------------------------------
// nonce_hit_fifo
// Small synchronous FIFO holding nonces whose hash met the target.
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle; otherwise it is refused (the caller flags the overflow).
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   push, push_data   write request and data
//   pop               read request (ignored when empty)
//   pop_data          oldest entry
//   full, empty       occupancy flags
// DEPTH must be a power of two, at least 2.
// ---------------------------------------------------------------------------
module nonce_hit_fifo
    import nonce_sweep_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = NS_WORDBITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    // When full, the slot being read this cycle frees up for the write.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/nonce_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// nonce_sweep_ctrl
// Sweeps a nonce range through an external fixed-latency hash pipeline.
// Each SWEEP cycle presents the job message with one word replaced by the
// current nonce and pushes a token into a PIPE_LAT-deep delay line, so the
// token reaches the head exactly when the pipeline returns that nonce's hash.
// Heads whose top hash word is <= target are queued in a hit FIFO.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   job_valid / job_ready      job handshake (ready only in IDLE)
//   job_msg                    message template
//   job_nonce_first/_last      inclusive sweep bounds (wraps through 0)
//   job_target                 hit threshold on the top hash word
//   msg_out                    message to the hash pipeline
//   hash_in                    finalized hash from the pipeline
//   hit_valid/hit_ready/hit_nonce  hit FIFO read side
//   busy, done, hit_overflow   status (done is a pulse, overflow is sticky)
//   abort                      only with NONCE_SWEEP_ABORT_EN: stop the sweep
//
// Build option: define NONCE_SWEEP_ABORT_EN to add the abort input.
// ---------------------------------------------------------------------------
module nonce_sweep_ctrl
    import nonce_sweep_pkg::*;
#(
    parameter int WORDBITS   = NS_WORDBITS,
    parameter int MSGWORDS   = NS_MSGWORDS,
    parameter int HASHWORDS  = NS_HASHWORDS,
    parameter int PIPE_LAT   = NS_PIPE_LAT,
    parameter int NONCE_WORD = 3,
    parameter int HIT_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          job_valid,
    output logic                          job_ready,
    input  logic [MSGWORDS*WORDBITS-1:0]  job_msg,
    input  logic [WORDBITS-1:0]           job_nonce_first,
    input  logic [WORDBITS-1:0]           job_nonce_last,
    input  logic [WORDBITS-1:0]           job_target,
    output logic [MSGWORDS*WORDBITS-1:0]  msg_out,
    input  logic [HASHWORDS*WORDBITS-1:0] hash_in,
    output logic                          hit_valid,
    input  logic                          hit_ready,
    output logic [WORDBITS-1:0]           hit_nonce,
    output logic                          busy,
    output logic                          done,
    output logic                          hit_overflow
`ifdef NONCE_SWEEP_ABORT_EN
    ,
    input  logic                          abort
`endif
);

    localparam int MSG_W = MSGWORDS * WORDBITS;
    localparam int CNT_W = $clog2(PIPE_LAT + 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(PIPE_LAT - 1);

    sweep_state_t        state;
    sweep_state_t        state_nxt;
    logic [MSG_W-1:0]    msg_q;
    logic [MSG_W-1:0]    msg_cur;
    logic [MSG_W-1:0]    msg_hold;
    logic [WORDBITS-1:0] nonce_q;
    logic [WORDBITS-1:0] last_q;
    logic [WORDBITS-1:0] target_q;
    logic [CNT_W-1:0]    drain_cnt;
    logic                accept;
    logic                issue;
    logic                drain_end;
    logic                abort_req;
    logic                tok_vld_p   [PIPE_LAT];
    logic [WORDBITS-1:0] tok_nonce_p [PIPE_LAT];
    logic [WORDBITS-1:0] hash_top;
    logic                hit_push;
    logic                hit_pop;
    logic                fifo_full;
    logic                fifo_empty;

`ifdef NONCE_SWEEP_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        job_ready = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        issue     = 1'b0;
        drain_end = 1'b0;
        unique case (state)
            ST_IDLE: begin
                job_ready = 1'b1;
                if (job_valid) begin
                    accept    = 1'b1;
                    state_nxt = ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                busy = 1'b1;
                if (abort_req) begin
                    state_nxt = ST_DRAIN;
                end else begin
                    issue = 1'b1;
                    if (nonce_q == last_q) state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (drain_cnt == DRAIN_LAST) begin
                    drain_end = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Job latch and nonce counter; data only, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            msg_q    <= job_msg;
            nonce_q  <= job_nonce_first;
            last_q   <= job_nonce_last;
            target_q <= job_target;
        end else if (issue) begin
            nonce_q <= nonce_q + 1'b1;
        end
    end

    always_comb begin
        msg_cur = msg_q;
        msg_cur[NONCE_WORD*WORDBITS +: WORDBITS] = nonce_q;
    end

    // msg_out is live while issuing and frozen at the last issued word otherwise.
    assign msg_out = issue ? msg_cur : msg_hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msg_hold     <= '0;
            drain_cnt    <= '0;
            done         <= 1'b0;
            hit_overflow <= 1'b0;
        end else begin
            if (issue) msg_hold <= msg_cur;
            if (state == ST_DRAIN) drain_cnt <= drain_cnt + 1'b1;
            else                   drain_cnt <= '0;
            done <= drain_end;
            if (accept)
                hit_overflow <= 1'b0;
            else if (hit_push && fifo_full && !hit_pop)
                hit_overflow <= 1'b1;
        end
    end

    // Stage boundary: token delay line, stage i visible i+1 cycles after issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PIPE_LAT; i++) tok_vld_p[i] <= 1'b0;
        end else begin
            tok_vld_p[0] <= issue;
            for (int i = 1; i < PIPE_LAT; i++) tok_vld_p[i] <= tok_vld_p[i-1];
        end
    end

    always_ff @(posedge clk) begin
        tok_nonce_p[0] <= nonce_q;
        for (int i = 1; i < PIPE_LAT; i++) tok_nonce_p[i] <= tok_nonce_p[i-1];
    end

    // Stage boundary: head token meets the hash of the same nonce.
    assign hash_top = hash_in[HASHWORDS*WORDBITS-1 -: WORDBITS];
    assign hit_push = tok_vld_p[PIPE_LAT-1] && (hash_top <= target_q);
    assign hit_pop  = hit_ready && !fifo_empty;

    generate
        if (HASHWORDS > 1) begin : g_hash_low
            logic unused_hash_low;
            assign unused_hash_low = ^hash_in[(HASHWORDS-1)*WORDBITS-1:0];
        end
    endgenerate

    nonce_hit_fifo #(
        .DEPTH (HIT_DEPTH),
        .WIDTH (WORDBITS)
    ) u_hit_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (hit_push),
        .push_data (tok_nonce_p[PIPE_LAT-1]),
        .pop       (hit_ready),
        .pop_data  (hit_nonce),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign hit_valid = !fifo_empty;

endmodule

// File: tb/tb_nonce_sweep_ctrl.sv
module tb_nonce_sweep_ctrl;

    localparam int WB = 32;
    localparam int MW = 16;
    localparam int HW = 8;
    localparam int PL = 16;
    localparam int NW = 3;
    localparam int MSGW = MW * WB;

    typedef struct {
        logic [31:0] first;
        logic [31:0] last;
        logic [31:0] target;
        bit          force_en;
        logic [31:0] force_val;
        int          ready_at;   // 0: ready throughout, >0: rises at that sweep offset, <0: held low
        int          keep;       // hits the FIFO is expected to retain from this job
        bit          exp_ovf;
        int          abort_at;   // <0: no abort
    } vec_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            job_valid;
    logic            job_ready;
    logic [MSGW-1:0] job_msg;
    logic [WB-1:0]   job_nonce_first;
    logic [WB-1:0]   job_nonce_last;
    logic [WB-1:0]   job_target;
    logic [MSGW-1:0] msg_out;
    logic [HW*WB-1:0] hash_in;
    logic            hit_valid;
    logic            hit_ready;
    logic [WB-1:0]   hit_nonce;
    logic            busy;
    logic            done;
    logic            hit_overflow;
`ifdef NONCE_SWEEP_ABORT_EN
    logic            abort;
`endif

    int total = 0;
    int bad = 0;
    int hits_seen = 0;
    logic [31:0] exp_q [$];
    logic [31:0] hist [PL+1];
    bit          force_en = 1'b0;
    logic [31:0] force_val = '0;
    logic [31:0] mon_e;
    vec_t        vecs [$];

    always #5 clk = ~clk;

    nonce_sweep_ctrl #(
        .WORDBITS   (WB),
        .MSGWORDS   (MW),
        .HASHWORDS  (HW),
        .PIPE_LAT   (PL),
        .NONCE_WORD (NW),
        .HIT_DEPTH  (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .job_valid       (job_valid),
        .job_ready       (job_ready),
        .job_msg         (job_msg),
        .job_nonce_first (job_nonce_first),
        .job_nonce_last  (job_nonce_last),
        .job_target      (job_target),
        .msg_out         (msg_out),
        .hash_in         (hash_in),
        .hit_valid       (hit_valid),
        .hit_ready       (hit_ready),
        .hit_nonce       (hit_nonce),
        .busy            (busy),
        .done            (done),
        .hit_overflow    (hit_overflow)
`ifdef NONCE_SWEEP_ABORT_EN
        ,
        .abort           (abort)
`endif
    );

    task automatic chk(input string name, input logic [MSGW-1:0] act, input logic [MSGW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Hash pipeline model: returns, PL cycles later, a hash whose top word is
    // the nonce word seen on msg_out (or a forced value).
    always @(negedge clk) begin
        for (int i = PL; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = msg_out[NW*WB +: WB];
        for (int w = 0; w < HW - 1; w++) hash_in[w*WB +: WB] = hist[PL] ^ (32'hA5A5_0000 + w);
        hash_in[HW*WB-1 -: WB] = force_en ? force_val : hist[PL];
    end

    // Scoreboard: every accepted hit must match the oldest expected nonce.
    always @(negedge clk) begin
        if (!rst && hit_valid && hit_ready) begin
            hits_seen++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_hit: got %0h want none", hit_nonce);
            end else begin
                mon_e = exp_q.pop_front();
                chk("hit_nonce", hit_nonce, mon_e);
            end
        end
    end

    function automatic vec_t mk(logic [31:0] f, logic [31:0] l, logic [31:0] t, bit fe,
                                logic [31:0] fv, int ra, int kp, bit ov, int ab);
        vec_t v;
        v.first = f; v.last = l; v.target = t; v.force_en = fe; v.force_val = fv;
        v.ready_at = ra; v.keep = kp; v.exp_ovf = ov; v.abort_at = ab;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        logic [MSGW-1:0] tmpl;
        logic [MSGW-1:0] expm;
        logic [31:0] cnt, n_iss, n_sweep, nn, top;
        int kept;
        bit got_done;
        cnt     = v.last - v.first + 32'd1;
        n_iss   = (v.abort_at >= 0) ? v.abort_at : cnt;
        n_sweep = (v.abort_at >= 0) ? v.abort_at + 1 : cnt;
        for (int w = 0; w < MW; w++) tmpl[w*WB +: WB] = $urandom;
        kept = 0;
        for (int unsigned i = 0; i < n_iss; i++) begin
            nn  = v.first + i;
            top = v.force_en ? v.force_val : nn;
            if (top <= v.target && kept < v.keep) begin
                exp_q.push_back(nn);
                kept++;
            end
        end
        @(posedge clk); #1;
        force_en  = v.force_en;
        force_val = v.force_val;
        hit_ready = (v.ready_at == 0);
        job_msg = tmpl; job_nonce_first = v.first; job_nonce_last = v.last;
        job_target = v.target; job_valid = 1'b1;
        @(negedge clk);
        chk("job_ready_idle", job_ready, 1);
        @(posedge clk); #1;
        job_valid = 1'b0;
        got_done = 1'b0;
        for (int k = 0; k < 200 && !got_done; k++) begin
            if (v.ready_at > 0 && k == v.ready_at) hit_ready = 1'b1;
`ifdef NONCE_SWEEP_ABORT_EN
            abort = (v.abort_at >= 0 && k == v.abort_at);
`endif
            @(negedge clk);
            if (k == 0) chk("ovf_clear", hit_overflow, 0);
            if (k < n_sweep) begin
                chk("busy_sweep", busy, 1);
                chk("job_ready_busy", job_ready, 0);
            end
            if (k < n_iss) begin
                expm = tmpl;
                expm[NW*WB +: WB] = v.first + k;
                chk("msg_issue", msg_out, expm);
            end else if (k == n_iss && n_iss > 0) begin
                expm = tmpl;
                expm[NW*WB +: WB] = v.first + n_iss - 1;
                chk("msg_hold", msg_out, expm);
            end
            if (done) begin
                got_done = 1'b1;
                chk("done_time", k, n_sweep + PL);
                chk("busy_idle", busy, 0);
                chk("ovf_at_done", hit_overflow, v.exp_ovf);
            end
            @(posedge clk); #1;
        end
`ifdef NONCE_SWEEP_ABORT_EN
        abort = 1'b0;
`endif
        if (!got_done) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done want done");
        end else begin
            @(negedge clk);
            chk("done_pulse", done, 0);
            chk("job_ready_after", job_ready, 1);
        end
    endtask

    task automatic drain_hits();
        @(posedge clk); #1;
        hit_ready = 1'b1;
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        chk("hits_pending", exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen0;
        for (int i = 0; i <= PL; i++) hist[i] = '0;
        rst = 1'b1; job_valid = 1'b0; job_msg = '0; job_nonce_first = '0;
        job_nonce_last = '0; job_target = '0; hit_ready = 1'b0;
`ifdef NONCE_SWEEP_ABORT_EN
        abort = 1'b0;
`endif
        vecs.push_back(mk(32'h10, 32'h13, 32'hFFFF_FFFF, 0, 0, 0, 4, 0, -1));
        vecs.push_back(mk(32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFF, 0, 0, 0, 4, 0, -1));
        vecs.push_back(mk(32'h10, 32'h13, 32'h12, 0, 0, 0, 4, 0, -1));
        vecs.push_back(mk(32'h55, 32'h55, 32'hFFFF_FFFF, 0, 0, 0, 4, 0, -1));
        vecs.push_back(mk(32'h20, 32'h27, 32'hFFFF_FFFF, 0, 0, -1, 4, 1, -1));
        vecs.push_back(mk(32'h30, 32'h33, 32'h0, 1, 32'h1, 0, 4, 0, -1));
        vecs.push_back(mk(32'h70, 32'h71, 32'h1, 1, 32'h1, 0, 4, 0, -1));
        vecs.push_back(mk(32'h20, 32'h27, 32'hFFFF_FFFF, 0, 0, PL + 4, 8, 0, -1));
`ifdef NONCE_SWEEP_ABORT_EN
        vecs.push_back(mk(32'h0, 32'h9, 32'hFFFF_FFFF, 0, 0, 0, 4, 0, 2));
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hit_valid", hit_valid, 0);
        chk("rst_ovf", hit_overflow, 0);
        chk("rst_msg", msg_out, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_job_ready", job_ready, 1);

        foreach (vecs[i]) begin
            run_vec(vecs[i]);
            drain_hits();
        end

        // Hits from two jobs held back must all survive the job boundary.
        run_vec(mk(32'h40, 32'h41, 32'hFFFF_FFFF, 0, 0, -1, 4, 0, -1));
        run_vec(mk(32'h50, 32'h50, 32'hFFFF_FFFF, 0, 0, -1, 4, 0, -1));
        drain_hits();

        // Fill the FIFO and overflow it, then reset in the middle of a sweep.
        run_vec(mk(32'h60, 32'h67, 32'hFFFF_FFFF, 0, 0, -1, 4, 1, -1));
        exp_q.delete();
        @(posedge clk); #1;
        job_msg = {MW{32'h1234_5678}}; job_nonce_first = 32'h100;
        job_nonce_last = 32'h11F; job_target = 32'hFFFF_FFFF; job_valid = 1'b1;
        @(posedge clk); #1;
        job_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_hit_valid", hit_valid, 0);
        chk("mid_rst_ovf", hit_overflow, 0);
        chk("mid_rst_msg", msg_out, 0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        hit_ready = 1'b1;
        seen0 = hits_seen;
        repeat (40) @(posedge clk);
        #1;
        chk("no_hit_after_rst", hits_seen - seen0, 0);
        chk("post_rst_job_ready", job_ready, 1);
        chk("post_rst_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
